// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks a layer's output tiles one at a time, waiting for each tile's store to finish
module conv_tile_sched #(
  parameter int M_TILES = 4,
  parameter int R_TILES = 3,
  parameter int C_TILES = 3,
  parameter int IDX_W = 8,
  parameter int AW = 32,
  parameter logic [AW-1:0] OUT_BASE = '0,
  parameter int TILE_BYTES = 1024,
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic conv_start,
  input  logic conv_store_done,
  output logic tile_start,
  output logic [IDX_W-1:0] tile_m,
  output logic [IDX_W-1:0] tile_r,
  output logic [IDX_W-1:0] tile_c,
  output logic [AW-1:0] tile_addr,
  output logic tile_last,
  output logic busy,
  output logic conv_done,
  output logic err_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [31:0] wdog;
  logic c_wrap, r_wrap;
  logic [IDX_W-1:0] m_nxt, r_nxt, c_nxt;
  assign tile_last = tile_m == IDX_W'(M_TILES - 1) && tile_r == IDX_W'(R_TILES - 1) && tile_c == IDX_W'(C_TILES - 1);
  // next tile in column, row, channel-group order
  always_comb begin
    c_wrap = tile_c == IDX_W'(C_TILES - 1);
    r_wrap = tile_r == IDX_W'(R_TILES - 1);
    c_nxt = c_wrap ? '0 : tile_c + 1'b1;
    r_nxt = c_wrap ? (r_wrap ? '0 : tile_r + 1'b1) : tile_r;
    m_nxt = (c_wrap && r_wrap) ? tile_m + 1'b1 : tile_m;
  end
  // scheduler FSM with registered outputs and store watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tile_m <= '0;
      tile_r <= '0;
      tile_c <= '0;
      tile_addr <= OUT_BASE;
      tile_start <= 1'b0;
      busy <= 1'b0;
      conv_done <= 1'b0;
      err_timeout <= 1'b0;
      wdog <= '0;
    end else begin
      tile_start <= 1'b0;
      conv_done <= 1'b0;
      case (state)
        IDLE: if (conv_start) begin
          state <= ISSUE;
          tile_start <= 1'b1;
          tile_m <= '0;
          tile_r <= '0;
          tile_c <= '0;
          tile_addr <= OUT_BASE;
          busy <= 1'b1;
          err_timeout <= 1'b0;
        end
        ISSUE: begin
          state <= WAIT;
          wdog <= '0;
        end
        WAIT: if (conv_store_done) begin
          if (tile_last) begin
            state <= IDLE;
            busy <= 1'b0;
            conv_done <= 1'b1;
          end else begin
            state <= ISSUE;
            tile_start <= 1'b1;
            tile_m <= m_nxt;
            tile_r <= r_nxt;
            tile_c <= c_nxt;
            tile_addr <= tile_addr + AW'(TILE_BYTES);
          end
        end else if (TIMEOUT != 0 && wdog != 32'(TIMEOUT)) begin
          wdog <= wdog + 32'd1;
          if (wdog + 32'd1 == 32'(TIMEOUT)) err_timeout <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
